// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared constants for the multiplier issue/collect stage:
//                operand/product widths and the 3-bit state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package mul_pkg;

    localparam int MUL_W  = 32;
    localparam int PROD_W = 64;

    // Issue-controller state encodings
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] OUTPUT    = 3'd4;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_issue_ctrl_if
//  Description : Bundle of the issue-stage handshakes and the multiplier link.
//                  in_*  : operand valid/ready channel (in_signed selects
//                          two's-complement operands when SIGNED_MUL_EN)
//                  mul_* : Run pulse, operands out; Ready, Product back
//                  out_* : one-entry result buffer valid/ready + error flag
//                slave  : view used by mul_issue_ctrl
//                master : view of the environment (producer, multiplier,
//                         consumer)
//  Revision    : 1.0  initial release
// ============================================================================
interface mul_issue_ctrl_if;
    import mul_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [MUL_W-1:0]  in_a;
    logic [MUL_W-1:0]  in_b;
    logic              in_signed;

    logic [MUL_W-1:0]  mul_Multiplicand;
    logic [MUL_W-1:0]  mul_Multiplier;
    logic              mul_Run;
    logic              mul_Ready;
    logic [PROD_W-1:0] mul_Product;

    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] out_product;
    logic              out_error;

    modport slave (
        input  in_valid, in_a, in_b, in_signed,
        output in_ready,
        output mul_Multiplicand, mul_Multiplier, mul_Run,
        input  mul_Ready, mul_Product,
        output out_valid, out_product, out_error,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_signed,
        input  in_ready,
        input  mul_Multiplicand, mul_Multiplier, mul_Run,
        output mul_Ready, mul_Product,
        input  out_valid, out_product, out_error,
        output out_ready
    );

endinterface : mul_issue_ctrl_if
`default_nettype wire

// File: rtl/mul_issue_ctrl_sign_fix.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sign_fix
//  Description : Combinational sign handling around an unsigned multiplier.
//                Ports:
//                  i_a, i_b      operands as received
//                  i_signed      operands are two's complement
//                  o_a_mag/o_b_mag  magnitudes (|-2^31| = 32'h8000_0000)
//                  o_neg         product must be negated (sign_a ^ sign_b)
//                  i_prod        unsigned product from the multiplier
//                  i_prod_neg    negate request latched with the operands
//                  o_prod        sign-corrected product
//  Revision    : 1.0  initial release
// ============================================================================
module mul_sign_fix
    import mul_pkg::*;
(
    input  wire logic [MUL_W-1:0]  i_a,
    input  wire logic [MUL_W-1:0]  i_b,
    input  wire logic              i_signed,
    output logic      [MUL_W-1:0]  o_a_mag,
    output logic      [MUL_W-1:0]  o_b_mag,
    output logic                   o_neg,
    input  wire logic [PROD_W-1:0] i_prod,
    input  wire logic              i_prod_neg,
    output logic      [PROD_W-1:0] o_prod
);

    logic w_sign_a;
    logic w_sign_b;

    assign w_sign_a = i_signed & i_a[MUL_W-1];
    assign w_sign_b = i_signed & i_b[MUL_W-1];

    // Negating -2^31 wraps back to 32'h8000_0000, which is the correct
    // unsigned magnitude, so no special case is required.
    assign o_a_mag = w_sign_a ? (~i_a + 1'b1) : i_a;
    assign o_b_mag = w_sign_b ? (~i_b + 1'b1) : i_b;
    assign o_neg   = w_sign_a ^ w_sign_b;

    assign o_prod  = i_prod_neg ? (~i_prod + 1'b1) : i_prod;

endmodule : mul_sign_fix
`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_issue_ctrl
//  Description : Issue/collect stage for the sequential 32x32 shift-add
//                multiplier. Accepts an operand pair, pulses mul_Run for one
//                cycle, waits for the multiplier to drop and then raise
//                mul_Ready, and parks the 64-bit product in a one-entry
//                output buffer. A hung multiplier is reported as an error
//                result (out_error=1, out_product=0) after TIMEOUT_CYC wait
//                cycles.
//                Ports:
//                  clk    rising-edge clock
//                  Reset  asynchronous active-high reset (shared with the
//                         multiplier)
//                  bus    mul_issue_ctrl_if.slave (in_*, mul_*, out_*)
//                Optional feature macro: SIGNED_MUL_EN (signed operands via
//                magnitude + product negate).
//  Revision    : 1.0  initial release
// ============================================================================
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int TIMEOUT_CYC = 40
)
(
    input  wire logic         clk,
    input  wire logic         Reset,
    mul_issue_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYC);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [MUL_W-1:0]  r_mcand;
    logic [MUL_W-1:0]  r_mplier;
    logic              r_out_valid;
    logic              r_out_error;
    logic [PROD_W-1:0] r_out_product;

    logic              w_accept;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_timeout;
    logic [MUL_W-1:0]  w_op_a;
    logic [MUL_W-1:0]  w_op_b;
    logic [PROD_W-1:0] w_prod_fixed;

`ifdef SIGNED_MUL_EN
    logic r_neg;
    logic w_op_neg;

    mul_sign_fix u_sign_fix (
        .i_a        (bus.in_a),
        .i_b        (bus.in_b),
        .i_signed   (bus.in_signed),
        .o_a_mag    (w_op_a),
        .o_b_mag    (w_op_b),
        .o_neg      (w_op_neg),
        .i_prod     (bus.mul_Product),
        .i_prod_neg (r_neg),
        .o_prod     (w_prod_fixed)
    );
`else
    // Unsigned-only build: in_signed has no effect.
    assign w_op_a       = bus.in_a;
    assign w_op_b       = bus.in_b;
    assign w_prod_fixed = bus.mul_Product;
`endif

    assign w_accept   = bus.in_valid && (r_state == IDLE);
    assign w_cnt_next = r_cnt + 1'b1;
    // Asserted on the TIMEOUT_CYC-th cycle spent waiting on the multiplier.
    assign w_timeout  = (w_cnt_next == C_TIMEOUT);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_out_valid   <= 1'b0;
            r_out_error   <= 1'b0;
            r_out_product <= '0;
`ifdef SIGNED_MUL_EN
            r_neg         <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= w_op_a;
                        r_mplier <= w_op_b;
`ifdef SIGNED_MUL_EN
                        r_neg    <= w_op_neg;
`endif
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A Ready still high from the previous operation is not
                    // a completion; wait until the multiplier goes busy.
                    r_cnt <= w_cnt_next;
                    if (w_timeout) begin
                        r_out_valid   <= 1'b1;
                        r_out_error   <= 1'b1;
                        r_out_product <= '0;
                        r_state       <= OUTPUT;
                    end else if (!bus.mul_Ready) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    r_cnt <= w_cnt_next;
                    // Completion takes priority over a coincident timeout.
                    if (bus.mul_Ready) begin
                        r_out_valid   <= 1'b1;
                        r_out_error   <= 1'b0;
                        r_out_product <= w_prod_fixed;
                        r_state       <= OUTPUT;
                    end else if (w_timeout) begin
                        r_out_valid   <= 1'b1;
                        r_out_error   <= 1'b1;
                        r_out_product <= '0;
                        r_state       <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_error <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready         = (r_state == IDLE);
    assign bus.mul_Run          = (r_state == ISSUE);
    assign bus.mul_Multiplicand = r_mcand;
    assign bus.mul_Multiplier   = r_mplier;
    assign bus.out_valid        = r_out_valid;
    assign bus.out_error        = r_out_error;
    assign bus.out_product      = r_out_product;

endmodule : mul_issue_ctrl
`default_nettype wire
